// File: rtl/mips_muldiv.sv
// Iterative multiply/divide unit owning HI/LO: MULT/MULTU/DIV/DIVU in 33 cycles
// (32 radix-2 iterations plus a sign-fix cycle), and MTHI/MTLO writes while idle.
module mips_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_b,
   input  logic             md_start,
   input  logic [1:0]       md_op,
   input  logic [WIDTH-1:0] md_in1,
   input  logic [WIDTH-1:0] md_in2,
   input  logic             md_hi_we,
   input  logic             md_lo_we,
   input  logic [WIDTH-1:0] md_wdata,
   output logic [WIDTH-1:0] md_hi,
   output logic [WIDTH-1:0] md_lo,
   output logic             md_busy,
   output logic             md_done
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIX  = 2'd2;
   localparam logic [5:0] LAST   = 6'(WIDTH - 1);

   function automatic logic [WIDTH-1:0] cneg_w(input logic [WIDTH-1:0] x, input logic n);
      return n ? (~x + 1'b1) : x;
   endfunction

   function automatic logic [2*WIDTH-1:0] cneg_2w(input logic [2*WIDTH-1:0] x, input logic n);
      return n ? (~x + 1'b1) : x;
   endfunction

   logic [1:0]       state_q, state_d;
   logic [5:0]       cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   // Working datapath: wh = accumulator / partial remainder, wl = multiplier / quotient.
   logic [WIDTH-1:0] wh_q, wh_d;
   logic [WIDTH-1:0] wl_q, wl_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             div_q, div_d;
   logic             neg_q, neg_d;
   logic             rneg_q, rneg_d;

   logic             a_neg, b_neg;
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   rem_sh;
   logic [WIDTH:0]   trial;

   assign sum    = {1'b0, wh_q} + (wl_q[0] ? {1'b0, b_q} : '0);
   assign rem_sh = {wh_q, wl_q[WIDTH-1]};
   assign trial  = rem_sh - {1'b0, b_q};

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
      hi_d    = hi_q;
      lo_d    = lo_q;
      wh_d    = wh_q;
      wl_d    = wl_q;
      b_d     = b_q;
      div_d   = div_q;
      neg_d   = neg_q;
      rneg_d  = rneg_q;
      a_neg   = ~md_op[0] & md_in1[WIDTH-1];
      b_neg   = ~md_op[0] & md_in2[WIDTH-1];
      case (state_q)
         S_IDLE: begin
            if (md_start) begin
               div_d   = md_op[1];
               neg_d   = a_neg ^ b_neg;
               rneg_d  = a_neg;
               b_d     = cneg_w(md_in2, b_neg);
               wl_d    = cneg_w(md_in1, a_neg);
               wh_d    = '0;
               cnt_d   = '0;
               busy_d  = 1'b1;
               state_d = S_CALC;
            end else begin
               if (md_hi_we) hi_d = md_wdata;
               if (md_lo_we) lo_d = md_wdata;
            end
         end
         S_CALC: begin
            if (div_q) begin
               wh_d = trial[WIDTH] ? rem_sh[WIDTH-1:0] : trial[WIDTH-1:0];
               wl_d = {wl_q[WIDTH-2:0], ~trial[WIDTH]};
            end else begin
               wh_d = sum[WIDTH:1];
               wl_d = {sum[0], wl_q[WIDTH-1:1]};
            end
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == LAST) state_d = S_FIX;
         end
         S_FIX: begin
            // A zero divisor leaves the dividend magnitude in wh, so the normal
            // remainder sign fix already reproduces the original dividend in HI.
            if (div_q) begin
               lo_d = (b_q == '0) ? '1 : cneg_w(wl_q, neg_q);
               hi_d = cneg_w(wh_q, rneg_q);
            end else begin
               {hi_d, lo_d} = cneg_2w({wh_q, wl_q}, neg_q);
            end
            cnt_d   = '0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hi_q    <= hi_d;
         lo_q    <= lo_d;
      end
   end

   always_ff @(posedge clk) begin
      wh_q   <= wh_d;
      wl_q   <= wl_d;
      b_q    <= b_d;
      div_q  <= div_d;
      neg_q  <= neg_d;
      rneg_q <= rneg_d;
   end

   assign md_hi   = hi_q;
   assign md_lo   = lo_q;
   assign md_busy = busy_q;
   assign md_done = done_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Self-checking bench for mips_muldiv: directed vector table, corner sequences,
// and random operations checked through a result scoreboard.
module tb_mips_muldiv;

   typedef struct {
      logic [31:0] hi;
      logic [31:0] lo;
   } exp_t;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   localparam logic [1:0] OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11;

   logic        clk = 1'b0;
   logic        rst_b;
   logic        md_start;
   logic [1:0]  md_op;
   logic [31:0] md_in1, md_in2, md_wdata;
   logic        md_hi_we, md_lo_we;
   logic [31:0] md_hi, md_lo;
   logic        md_busy, md_done;

   int   checks = 0;
   int   failures = 0;
   int   done_cnt = 0;
   int   cyc = 0;
   exp_t sbq[$];
   exp_t mon_e;
   vec_t tbl[14];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mips_muldiv #(.WIDTH(32)) dut (
      .clk(clk), .rst_b(rst_b), .md_start(md_start), .md_op(md_op),
      .md_in1(md_in1), .md_in2(md_in2), .md_hi_we(md_hi_we), .md_lo_we(md_lo_we),
      .md_wdata(md_wdata), .md_hi(md_hi), .md_lo(md_lo), .md_busy(md_busy),
      .md_done(md_done)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, req);
      end
   endtask

   function automatic exp_t model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      exp_t        e;
      longint      p;
      logic [63:0] ua, ub, up;
      int          sa, sb;
      sa = a;
      sb = b;
      ua = {32'b0, a};
      ub = {32'b0, b};
      case (op)
         OP_MULT: begin
            p = longint'(sa) * longint'(sb);
            up = p;
            e.hi = up[63:32];
            e.lo = up[31:0];
         end
         OP_MULTU: begin
            up = ua * ub;
            e.hi = up[63:32];
            e.lo = up[31:0];
         end
         OP_DIV: begin
            if (b == 32'h0) begin
               e.hi = a; e.lo = 32'hFFFF_FFFF;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               e.hi = 32'h0; e.lo = 32'h8000_0000;
            end else begin
               e.lo = sa / sb;
               e.hi = sa % sb;
            end
         end
         default: begin
            if (b == 32'h0) begin
               e.hi = a; e.lo = 32'hFFFF_FFFF;
            end else begin
               e.lo = a / b;
               e.hi = a % b;
            end
         end
      endcase
      return e;
   endfunction

   // Scoreboard: every done pulse must match the oldest outstanding result.
   always @(negedge clk) begin
      if (md_done === 1'b1) begin
         done_cnt++;
         if (sbq.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_done actual=1 required=0");
         end else begin
            mon_e = sbq.pop_front();
            chk("result_hi", {32'b0, md_hi}, {32'b0, mon_e.hi});
            chk("result_lo", {32'b0, md_lo}, {32'b0, mon_e.lo});
         end
      end
   end

   // Called at a falling edge; start is sampled on the following rising edge.
   task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                           input exp_t e);
      md_start = 1'b1;
      md_op    = op;
      md_in1   = a;
      md_in2   = b;
      sbq.push_back(e);
      @(negedge clk);
      md_start = 1'b0;
      chk("busy_after_start", {63'b0, md_busy}, 64'd1);
   endtask

   task automatic wait_done(input int exp_lat);
      int n = 0;
      while (md_done !== 1'b1 && n < 60) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 64'(n), 64'(exp_lat));
      chk("busy_at_done", {63'b0, md_busy}, 64'd0);
   endtask

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 7))
         0: return 32'h0000_0000;
         1: return 32'h0000_0001;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         5: return 32'($urandom_range(0, 15));
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int   t1, t2, dc;
      exp_t e;
      logic [1:0]  rop;
      logic [31:0] ra, rb;

      tbl[0]  = '{OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
      tbl[1]  = '{OP_MULT,  32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
      tbl[2]  = '{OP_DIV,   32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
      tbl[3]  = '{OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14};
      tbl[4]  = '{OP_DIVU,  32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};
      tbl[5]  = '{OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000};
      tbl[6]  = '{OP_DIV,   32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF};
      tbl[7]  = '{OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};
      tbl[8]  = '{OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0};
      tbl[9]  = '{OP_MULT,  32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0001};
      tbl[10] = '{OP_MULTU, 32'h0,         32'h1234_5678, 32'h0,         32'h0};
      tbl[11] = '{OP_DIVU,  32'd3,         32'd9,         32'd3,         32'd0};
      tbl[12] = '{OP_DIV,   32'h8000_0000, 32'd2,         32'h0,         32'hC000_0000};
      tbl[13] = '{OP_DIV,   32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF};

      rst_b = 1'b0; md_start = 1'b0; md_op = 2'b00; md_in1 = '0; md_in2 = '0;
      md_hi_we = 1'b0; md_lo_we = 1'b0; md_wdata = '0;
      repeat (3) @(negedge clk);
      chk("reset_hi", {32'b0, md_hi}, 64'd0);
      chk("reset_lo", {32'b0, md_lo}, 64'd0);
      chk("reset_busy", {63'b0, md_busy}, 64'd0);
      chk("reset_done", {63'b0, md_done}, 64'd0);
      rst_b = 1'b1;
      @(negedge clk);

      for (int i = 0; i < 14; i++) begin
         e.hi = tbl[i].hi;
         e.lo = tbl[i].lo;
         start_op(tbl[i].op, tbl[i].a, tbl[i].b, e);
         wait_done(33);
      end
      @(negedge clk);
      chk("done_one_cycle", {63'b0, md_done}, 64'd0);

      md_hi_we = 1'b1; md_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      md_hi_we = 1'b0;
      chk("mthi", {32'b0, md_hi}, 64'h0000_0000_DEAD_BEEF);
      md_hi_we = 1'b1; md_lo_we = 1'b1; md_wdata = 32'h0BAD_F00D;
      @(negedge clk);
      md_hi_we = 1'b0; md_lo_we = 1'b0;
      chk("mthi_both", {32'b0, md_hi}, 64'h0000_0000_0BAD_F00D);
      chk("mtlo_both", {32'b0, md_lo}, 64'h0000_0000_0BAD_F00D);

      start_op(OP_MULT, 32'hFFFF_FFF9, 32'd3, model(OP_MULT, 32'hFFFF_FFF9, 32'd3));
      repeat (5) @(negedge clk);
      md_lo_we = 1'b1; md_wdata = 32'h1234_5678;
      @(negedge clk);
      md_lo_we = 1'b0;
      chk("lo_we_busy_ignored", {32'b0, md_lo}, 64'h0000_0000_0BAD_F00D);
      md_start = 1'b1; md_op = OP_DIVU; md_in1 = 32'd1; md_in2 = 32'd1;
      @(negedge clk);
      md_start = 1'b0;
      chk("hi_stable_busy", {32'b0, md_hi}, 64'h0000_0000_0BAD_F00D);
      dc = done_cnt;
      wait_done(26);
      repeat (40) @(negedge clk);
      chk("no_second_done", 64'(done_cnt), 64'(dc + 1));

      md_hi_we = 1'b1; md_wdata = 32'hFFFF_0000;
      start_op(OP_DIVU, 32'd100, 32'd7, model(OP_DIVU, 32'd100, 32'd7));
      md_hi_we = 1'b0;
      chk("start_beats_write", {32'b0, md_hi}, 64'h0000_0000_FFFF_FFFF);
      wait_done(33);

      start_op(OP_MULT, 32'd5, 32'd6, model(OP_MULT, 32'd5, 32'd6));
      repeat (9) @(negedge clk);
      rst_b = 1'b0;
      #1;
      chk("abort_hi", {32'b0, md_hi}, 64'd0);
      chk("abort_lo", {32'b0, md_lo}, 64'd0);
      chk("abort_busy", {63'b0, md_busy}, 64'd0);
      chk("abort_done", {63'b0, md_done}, 64'd0);
      sbq.delete();
      @(negedge clk);
      rst_b = 1'b1;
      @(negedge clk);
      e.hi = 32'd0; e.lo = 32'd3;
      start_op(OP_DIVU, 32'd9, 32'd3, e);
      wait_done(33);
      t1 = cyc;
      start_op(OP_MULTU, 32'd12, 32'd13, model(OP_MULTU, 32'd12, 32'd13));
      wait_done(33);
      t2 = cyc;
      chk("b2b_gap", 64'(t2 - t1), 64'd34);

      for (int i = 0; i < 1500; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = pick();
         rb  = pick();
         start_op(rop, ra, rb, model(rop, ra, rb));
         wait_done(33);
      end
      @(negedge clk);
      chk("scoreboard_empty", 64'(sbq.size()), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
